dmem_port: RTL and testbench

Parametrised data-memory port: the next generation of the single-cycle data memory behind the CPU's `io_dmem_*` bus. It keeps the valid/good request handshake, byte/half/word masking and sign extension. It adds configurable depth and wait-state latency, misalignment/illegal-mode error reporting, and a full-word readBack. It sits between the CPU data port and an internal word-organised storage array.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_port_if.sv | 29 ++
 rtl/dmem_lane_align.sv | 31 +++
 rtl/dmem_port.sv | 155 +++++++++++++++
 tb/tb_dmem_port.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: mask-mode encodings, FSM state
// type and byte-lane helpers used by the top level.
package dmem_pkg;

    localparam logic [1:0] MASK_B = 2'd0;
    localparam logic [1:0] MASK_H = 2'd1;
    localparam logic [1:0] MASK_W = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Byte-lane enables for an access of the given size at byte offset.
    function automatic logic [3:0] byte_enable(input logic [1:0] mode,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (mode)
            MASK_B:  be = 4'b0001 << offset;
            MASK_H:  be = offset[1] ? 4'b1100 : 4'b0011;
            MASK_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Widen a byte-enable vector into a 32-bit bit mask.
    function automatic logic [31:0] expand_be(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dmem_port_if.sv
// CPU data-port bus bundle.
//   master (CPU): drives addr, valid, writeData, memRead, memWrite, maskMode, sext;
//                 receives good, readData, readBack, err.
//   slave (memory port): the mirror image.
interface dmem_port_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              good;
    logic [31:0]       writeData;
    logic              memRead;
    logic              memWrite;
    logic [1:0]        maskMode;
    logic              sext;
    logic [31:0]       readData;
    logic [31:0]       readBack;
    logic              err;

    modport master (
        output addr, valid, writeData, memRead, memWrite, maskMode, sext,
        input  good, readData, readBack, err
    );

    modport slave (
        input  addr, valid, writeData, memRead, memWrite, maskMode, sext,
        output good, readData, readBack, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Load-path lane selection: picks the addressed byte/half out of a word,
// right-aligns it and sign- or zero-extends it to 32 bits.
//   word   - full storage word
//   offset - byte offset addr[1:0]
//   mode   - access size (byte/half/word; illegal yields 0)
//   sext   - 1 = sign-extend, 0 = zero-extend
//   data   - aligned, extended result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  mode,
    input  logic        sext,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (mode)
            MASK_B:  data = {{24{sext & byte_sel[7]}}, byte_sel};
            MASK_H:  data = {{16{sext & half_sel[15]}}, half_sel};
            MASK_W:  data = word;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/dmem_port.sv
// Data-memory port with valid/good handshake, configurable wait states,
// byte/half/word masking, sign extension and misalignment reporting.
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - slave side of dmem_port_if (request in, good/readData/readBack/err out)
module dmem_port
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 0
) (
    input logic        clk,
    input logic        reset,
    dmem_port_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned LOW_W    = IDX_W + 2;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    function automatic logic is_bad(input logic [1:0] mode, input logic [1:0] offset);
        return (mode == 2'd3) || (mode == MASK_H && offset[0]) ||
               (mode == MASK_W && offset != 2'd0);
    endfunction

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [LOW_W-1:0] addr_q;
    logic [1:0]       mode_q;
    logic             sext_q, read_q, write_q;
    logic             good_q, err_q;
    logic [31:0]      read_data_q, read_back_q;
    logic [31:0]      mem [DEPTH];

    // Address bits above the array are ignored (addresses wrap).
    logic unused_addr;
    assign unused_addr = ^bus.addr[ADDR_W-1:LOW_W];

    // Request as seen by the edge that enters RESP: live inputs in IDLE
    // (zero-latency case), captured copy while waiting.
    logic [LOW_W-1:0] src_addr;
    logic [1:0]       src_mode;
    logic             src_sext, src_read, src_write, src_err;
    logic [IDX_W-1:0] src_idx;

    always_comb begin
        if (state_q == StIdle) begin
            src_addr  = bus.addr[LOW_W-1:0];
            src_mode  = bus.maskMode;
            src_sext  = bus.sext;
            src_read  = bus.memRead;
            src_write = bus.memWrite;
        end else begin
            src_addr  = addr_q;
            src_mode  = mode_q;
            src_sext  = sext_q;
            src_read  = read_q;
            src_write = write_q;
        end
        src_err = is_bad(src_mode, src_addr[1:0]);
        src_idx = src_addr[LOW_W-1:2];
    end

    logic        store_now;
    logic [31:0] rd_word, lanes, bit_mask, merged, aligned, load_data;

    assign store_now = reset && (state_q == StIdle) && bus.valid && bus.memWrite && !src_err;
    assign rd_word   = mem[src_idx];
    assign bit_mask  = expand_be(byte_enable(src_mode, src_addr[1:0]));

    // Replicate right-aligned store data across lanes; the mask picks the target.
    always_comb begin
        case (src_mode)
            MASK_B:  lanes = {4{bus.writeData[7:0]}};
            MASK_H:  lanes = {2{bus.writeData[15:0]}};
            default: lanes = bus.writeData;
        endcase
    end

    // Word after this edge's store, so a zero-latency readBack shows the new data.
    assign merged = store_now ? ((rd_word & ~bit_mask) | (lanes & bit_mask)) : rd_word;

    dmem_lane_align u_align (
        .word   (rd_word),
        .offset (src_addr[1:0]),
        .mode   (src_mode),
        .sext   (src_sext),
        .data   (aligned)
    );

    assign load_data = (src_read && !src_write && !src_err) ? aligned : '0;

    always_ff @(posedge clk) begin
        if (store_now) begin
            mem[src_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            mode_q      <= '0;
            sext_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            good_q      <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= '0;
            read_back_q <= '0;
        end else begin
            good_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.valid) begin
                        addr_q  <= src_addr;
                        mode_q  <= src_mode;
                        sext_q  <= src_sext;
                        read_q  <= src_read;
                        write_q <= src_write;
                        if (LATENCY == 0) begin
                            state_q     <= StResp;
                            good_q      <= 1'b1;
                            err_q       <= src_err;
                            read_data_q <= load_data;
                            read_back_q <= merged;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= StResp;
                        good_q      <= 1'b1;
                        err_q       <= src_err;
                        read_data_q <= load_data;
                        read_back_q <= merged;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.good     = good_q;
    assign bus.err      = err_q;
    assign bus.readData = read_data_q;
    assign bus.readBack = read_back_q;
endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_port_if #(.ADDR_W(32)) bus0 ();
    dmem_port_if #(.ADDR_W(32)) bus3 ();

    dmem_port #(.ADDR_W(32), .DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_port #(.ADDR_W(32), .DEPTH(16), .LATENCY(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic drive(input int which, input logic v, input logic [31:0] a, wd,
                         input logic rd, wr, input logic [1:0] mode, input logic sx);
        if (which == 0) begin
            bus0.valid = v; bus0.addr = a; bus0.writeData = wd;
            bus0.memRead = rd; bus0.memWrite = wr; bus0.maskMode = mode; bus0.sext = sx;
        end else begin
            bus3.valid = v; bus3.addr = a; bus3.writeData = wd;
            bus3.memRead = rd; bus3.memWrite = wr; bus3.maskMode = mode; bus3.sext = sx;
        end
    endtask

    function automatic logic good_of(input int which);
        return (which == 0) ? bus0.good : bus3.good;
    endfunction

    // One request; lat = negedges from acceptance to good (-1 on timeout),
    // one_shot = good dropped the cycle after it pulsed.
    task automatic do_req(input int which, input logic [31:0] a, wd, input logic rd, wr,
                          input logic [1:0] mode, input logic sx,
                          input bit poke, input logic [31:0] a_alt,
                          output int lat, output logic [31:0] rdata, rback,
                          output logic e, output logic one_shot);
        bit got = 0;
        lat = -1; rdata = 'x; rback = 'x; e = 1'bx;
        @(negedge clk);
        drive(which, 1'b1, a, wd, rd, wr, mode, sx);
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (poke && c == 1) drive(which, 1'b1, a_alt, wd, rd, wr, MASK_B, ~sx);
            if (good_of(which) === 1'b1) begin
                got = 1; lat = c;
                rdata = (which == 0) ? bus0.readData : bus3.readData;
                rback = (which == 0) ? bus0.readBack : bus3.readBack;
                e     = (which == 0) ? bus0.err : bus3.err;
            end
        end
        drive(which, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, MASK_W, 1'b0);
        @(negedge clk);
        one_shot = got && (good_of(which) === 1'b0);
    endtask

    int lat;
    logic [31:0] rdata, rback;
    logic e, one;

    task automatic test_reset;
        #12;
        total++; if (bus0.good !== 1'b0) begin bad++; $display("FAIL rst_good0 got=%b want=0", bus0.good); end
        total++; if (bus0.readData !== 32'h0) begin bad++; $display("FAIL rst_rdata0 got=%h want=0", bus0.readData); end
        total++; if (bus0.readBack !== 32'h0) begin bad++; $display("FAIL rst_rback0 got=%h want=0", bus0.readBack); end
        total++; if (bus3.err !== 1'b0 || bus3.good !== 1'b0) begin bad++; $display("FAIL rst_dut3 got=%b%b want=00", bus3.err, bus3.good); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word;
        do_req(0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (lat !== 1) begin bad++; $display("FAIL st_word_lat got=%0d want=1", lat); end
        total++; if (one !== 1'b1) begin bad++; $display("FAIL st_word_oneshot got=%b want=1", one); end
        total++; if (rback !== 32'hDEADBEEF || rdata !== 32'h0 || e !== 1'b0) begin bad++;
            $display("FAIL st_word got=%h/%h/%b want=deadbeef/00000000/0", rback, rdata, e); end
        do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (lat !== 1) begin bad++; $display("FAIL ld_word_lat got=%0d want=1", lat); end
        total++; if (rdata !== 32'hDEADBEEF || e !== 1'b0) begin bad++;
            $display("FAIL ld_word got=%h/%b want=deadbeef/0", rdata, e); end
    endtask

    task automatic test_extend;
        do_req(0, 32'h13, 32'h0, 1'b1, 1'b0, MASK_B, 1'b1, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'hFFFFFFDE) begin bad++; $display("FAIL ld_byte_sx got=%h want=ffffffde", rdata); end
        do_req(0, 32'h13, 32'h0, 1'b1, 1'b0, MASK_B, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'h000000DE) begin bad++; $display("FAIL ld_byte_zx got=%h want=000000de", rdata); end
        do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, MASK_H, 1'b1, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'hFFFFBEEF) begin bad++; $display("FAIL ld_half_sx got=%h want=ffffbeef", rdata); end
        do_req(0, 32'h12, 32'h0, 1'b1, 1'b0, MASK_H, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'h0000DEAD || rback !== 32'hDEADBEEF) begin bad++;
            $display("FAIL ld_half_hi got=%h/%h want=0000dead/deadbeef", rdata, rback); end
    endtask

    task automatic test_partial_store;
        do_req(0, 32'h11, 32'hFFFFFF55, 1'b0, 1'b1, MASK_B, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (rback !== 32'hDEAD55EF || rdata !== 32'h0) begin bad++;
            $display("FAIL st_byte got=%h/%h want=dead55ef/00000000", rback, rdata); end
        do_req(0, 32'h12, 32'h00001234, 1'b0, 1'b1, MASK_H, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (rback !== 32'h123455EF) begin bad++; $display("FAIL st_half got=%h want=123455ef", rback); end
        do_req(0, 32'h11, 32'h0, 1'b1, 1'b0, MASK_B, 1'b1, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'h00000055) begin bad++; $display("FAIL ld_byte_pos got=%h want=00000055", rdata); end
    endtask

    task automatic test_errors;
        do_req(0, 32'h12, 32'hCAFEF00D, 1'b0, 1'b1, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (e !== 1'b1 || rback !== 32'h123455EF || rdata !== 32'h0) begin bad++;
            $display("FAIL st_misalign got=%b/%h/%h want=1/123455ef/00000000", e, rback, rdata); end
        do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'h123455EF || e !== 1'b0) begin bad++;
            $display("FAIL unchanged got=%h/%b want=123455ef/0", rdata, e); end
        do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, 2'd3, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (e !== 1'b1 || rdata !== 32'h0 || rback !== 32'h123455EF) begin bad++;
            $display("FAIL ld_illegal got=%b/%h/%h want=1/00000000/123455ef", e, rdata, rback); end
        do_req(0, 32'h11, 32'h0, 1'b1, 1'b0, MASK_H, 1'b1, 0, 0, lat, rdata, rback, e, one);
        total++; if (e !== 1'b1 || rdata !== 32'h0) begin bad++;
            $display("FAIL ld_half_misalign got=%b/%h want=1/00000000", e, rdata); end
        do_req(0, 32'h10, 32'h0, 1'b0, 1'b0, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (lat !== 1 || e !== 1'b0 || rdata !== 32'h0 || rback !== 32'h123455EF) begin bad++;
            $display("FAIL noop got=%0d/%b/%h/%h want=1/0/00000000/123455ef", lat, e, rdata, rback); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(0, 1'b1, 32'h18, 32'h0BADF00D, 1'b0, 1'b1, MASK_W, 1'b0);
        @(negedge clk);
        total++; if (bus0.good !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b want=1", bus0.good); end
        drive(0, 1'b1, 32'h18, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0);
        @(negedge clk);
        total++; if (bus0.good !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", bus0.good); end
        @(negedge clk);
        total++; if (bus0.good !== 1'b1 || bus0.readData !== 32'h0BADF00D) begin bad++;
            $display("FAIL b2b_second got=%b/%h want=1/0badf00d", bus0.good, bus0.readData); end
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, MASK_W, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_latency3;
        do_req(3, 32'h14, 32'h11223344, 1'b0, 1'b1, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (lat !== 4 || rback !== 32'h11223344) begin bad++;
            $display("FAIL l3_store14 got=%0d/%h want=4/11223344", lat, rback); end
        do_req(3, 32'h10, 32'hA5A50F0F, 1'b0, 1'b1, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (lat !== 4 || one !== 1'b1) begin bad++;
            $display("FAIL l3_timing got=%0d/%b want=4/1", lat, one); end
        do_req(3, 32'h10, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0, 1, 32'h15, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'hA5A50F0F || e !== 1'b0) begin bad++;
            $display("FAIL l3_addr_change got=%h/%b want=a5a50f0f/0", rdata, e); end
        do_req(3, 32'h50, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (rdata !== 32'hA5A50F0F || rback !== 32'hA5A50F0F) begin bad++;
            $display("FAIL l3_alias got=%h/%h want=a5a50f0f/a5a50f0f", rdata, rback); end
    endtask

    task automatic test_reset_mid_wait;
        bit seen = 0;
        @(negedge clk);
        drive(3, 1'b1, 32'h14, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0);
        @(negedge clk);
        drive(3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, MASK_W, 1'b0);
        reset = 1'b0;
        #1;
        total++; if (bus3.readData !== 32'h0 || bus3.readBack !== 32'h0 || bus3.err !== 1'b0) begin bad++;
            $display("FAIL rst_wait_outs got=%h/%h/%b want=0/0/0", bus3.readData, bus3.readBack, bus3.err); end
        total++; if (bus0.readBack !== 32'h0) begin bad++; $display("FAIL rst_wait_dut0 got=%h want=0", bus0.readBack); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b1;
            if (bus3.good !== 1'b0) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_wait_nogood got=%b want=0", seen); end
        do_req(3, 32'h10, 32'h0, 1'b1, 1'b0, MASK_W, 1'b0, 0, 0, lat, rdata, rback, e, one);
        total++; if (lat !== 4 || rdata !== 32'hA5A50F0F) begin bad++;
            $display("FAIL rst_recover got=%0d/%h want=4/a5a50f0f", lat, rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, MASK_W, 1'b0);
        drive(3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, MASK_W, 1'b0);
        test_reset();
        test_word();
        test_extend();
        test_partial_store();
        test_errors();
        test_back_to_back();
        test_latency3();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
